rr_arbiter: RTL and testbench
=============================

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..16).
REQ-002 Parameter MAX_HOLD, default 8, max consecutive grant cycles for one holder while others wait (1..255).
REQ-003 Port clk  input  1  single clock, all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port request  input  N_REQ  per-requester request, level-sensitive.
REQ-006 Port mode  input  1  0 = fixed priority (index 0 highest), 1 = round robin.
REQ-007 Port grant  output  N_REQ  registered grant, one-hot or zero.
REQ-008 Port grant_id  output  $clog2(N_REQ)  index of the granted requester, 0 when grant is zero.
REQ-009 Port grant_valid  output  1  high iff grant is non-zero.

Function
REQ-010 grant SHALL never have more than one bit set.
REQ-011 States SHALL be IDLE (no grant) and BUSY (one holder).
REQ-012 IDLE -> BUSY: any request bit high at an edge SHALL produce grant on that edge (one-cycle latency from request to grant).
REQ-013 BUSY, holder request high, hold_cnt < MAX_HOLD: grant SHALL stay on the holder and hold_cnt SHALL increment.
REQ-014 BUSY, holder request high, hold_cnt = MAX_HOLD, another request pending: grant SHALL move to the next winner on that edge (forced rotation), hold_cnt reset to 1.
REQ-015 BUSY, holder request high, hold_cnt = MAX_HOLD, no other request: grant SHALL stay, hold_cnt SHALL saturate at MAX_HOLD.
REQ-016 BUSY, holder request low: the same edge SHALL re-arbitrate among current requests (no idle gap); none pending -> IDLE, grant 0.
REQ-017 Winner in round-robin mode: first requester with request high searching upward (with wrap) from last_grant+1; holder is excluded only on forced rotation.
REQ-018 Winner in fixed mode: lowest-index request high; forced rotation picks lowest-index request excluding holder.
REQ-019 last_grant SHALL update to the new winner on every edge where grant changes to a non-zero value; it SHALL hold in IDLE.
REQ-020 mode SHALL be sampled only at arbitration edges; a mode change never revokes a current holder.
REQ-021 hold_cnt SHALL be 1 in the first grant cycle; width $clog2(MAX_HOLD+1).
REQ-022 grant_id and grant_valid SHALL be registered with grant (same cycle).

Reset
REQ-023 Assertion of reset SHALL immediately clear grant, grant_id, grant_valid, hold_cnt, and force IDLE, including mid-grant.
REQ-024 last_grant SHALL reset to N_REQ-1 so that requester 0 has first round-robin priority.
REQ-025 First edge after reset deassertion SHALL arbitrate normally per REQ-012.

Structure
REQ-026 Package arbiter_pkg SHALL hold the state enum (IDLE, BUSY) and mode enum (MODE_FIXED, MODE_RR).
REQ-027 Sub-module rr_pick SHALL implement the combinational masked priority search (request, start index, exclude mask -> one-hot winner, index, found).
REQ-028 Interface arb_if SHALL be extended with the N_REQ parameter, mode, grant_id and grant_valid.

Verification (N_REQ=4, MAX_HOLD=4)
REQ-029 Reset, request=4'b0000 held -> grant=0, grant_valid=0 on all edges.
REQ-030 mode=1, request=4'b1111 held and each holder drops its request after 1 cycle and re-raises it -> grant sequence 0001,0010,0100,1000,0001.
REQ-031 mode=1, request=4'b0011 held continuously -> 0001 for 4 cycles, then 0010 for 4 cycles, then 0001.
REQ-032 request=4'b0001 alone held 10 cycles -> grant 0001 all 10 cycles, hold_cnt saturates at 4.
REQ-033 mode=0, request=4'b1100 held, then request[0] raised after 2 cycles -> 0100 holds to MAX_HOLD, then 0001 wins.
REQ-034 Reset asserted mid-grant between edges -> grant=0 immediately; after release with request=4'b1000 -> grant=1000 on next edge.

Source files
------------

// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared types and helpers for the request arbiter
package arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } arb_mode_t;

    // Round-robin search begins one past the previous winner, wrapping.
    function automatic int rr_next(input int last, input int n_req);
        return (last + 1) % n_req;
    endfunction

endpackage

// File: rtl/arb_if.sv
// rtl/arb_if.sv - bundle of arbiter request/grant signals
interface arb_if #(
    parameter int N_REQ = 4
) (
    input logic clk,
    input logic reset
);
    localparam int W = $clog2(N_REQ);

    logic [N_REQ-1:0] request;
    logic             mode;
    logic [N_REQ-1:0] grant;
    logic [W-1:0]     grant_id;
    logic             grant_valid;

    modport arbiter (
        input  clk, reset, request, mode,
        output grant, grant_id, grant_valid
    );

    modport client (
        input  clk, reset, grant, grant_id, grant_valid,
        output request, mode
    );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - masked circular priority search returning a one-hot winner
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int W    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] request,
    input  logic [W-1:0]     start,
    input  logic [N_REQ-1:0] exclude,
    output logic [N_REQ-1:0] winner,
    output logic [W-1:0]     winner_id,
    output logic             found
);

    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        winner_id = '0;
        found     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(start) + i) % N_REQ;
            if (!found && request[idx] && !exclude[idx]) begin
                winner[idx] = 1'b1;
                winner_id   = W'(idx);
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - fixed/round-robin arbiter with bounded hold and forced rotation
module rr_arbiter
    import arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    localparam int W       = $clog2(N_REQ),
    localparam int HW      = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] request,
    input  logic             mode,
    output logic [N_REQ-1:0] grant,
    output logic [W-1:0]     grant_id,
    output logic             grant_valid
);

    arb_state_t       state, state_n;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic [W-1:0]     last_grant, last_n;
    logic [N_REQ-1:0] grant_n;
    logic [W-1:0]     grant_id_n;
    logic             valid_n;

    arb_mode_t        mode_e;
    logic [W-1:0]     pick_start;
    logic [N_REQ-1:0] pick_excl;
    logic [N_REQ-1:0] pick_winner;
    logic [W-1:0]     pick_id;
    logic             pick_found;
    logic             holder_req;
    logic             others_req;
    logic             saturated;

    assign mode_e     = arb_mode_t'(mode);
    assign holder_req = |(request & grant);
    assign others_req = |(request & ~grant);
    assign saturated  = (hold_cnt == HW'(MAX_HOLD));
    assign pick_start = (mode_e == MODE_RR) ? W'(rr_next(int'(last_grant), N_REQ)) : '0;
    // Only a forced rotation keeps the current holder out of the search.
    assign pick_excl  = (state == BUSY && holder_req && saturated) ? grant : '0;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .request   (request),
        .start     (pick_start),
        .exclude   (pick_excl),
        .winner    (pick_winner),
        .winner_id (pick_id),
        .found     (pick_found)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            hold_cnt    <= '0;
            last_grant  <= W'(N_REQ - 1);
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            grant_id    <= grant_id_n;
            grant_valid <= valid_n;
            hold_cnt    <= hold_n;
            last_grant  <= last_n;
        end
    end

    always_comb begin
        logic reelect;
        reelect    = 1'b0;
        state_n    = state;
        grant_n    = grant;
        grant_id_n = grant_id;
        valid_n    = grant_valid;
        hold_n     = hold_cnt;
        last_n     = last_grant;

        case (state)
            IDLE: reelect = |request;
            BUSY: begin
                if (holder_req) begin
                    if (!saturated)
                        hold_n = hold_cnt + 1'b1;
                    else if (others_req)
                        reelect = 1'b1;
                end else if (|request) begin
                    reelect = 1'b1;
                end else begin
                    state_n    = IDLE;
                    grant_n    = '0;
                    grant_id_n = '0;
                    valid_n    = 1'b0;
                    hold_n     = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        if (reelect && pick_found) begin
            state_n    = BUSY;
            grant_n    = pick_winner;
            grant_id_n = pick_id;
            valid_n    = 1'b1;
            hold_n     = HW'(1);
            last_n     = pick_id;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - randomized and directed checks of rr_arbiter against a behavioural model
module tb_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   run_cmp = 1'b0;

    arb_if #(.N_REQ(N)) bus (.clk(clk), .reset(reset));

    rr_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .clk         (clk),
        .reset       (reset),
        .request     (bus.request),
        .mode        (bus.mode),
        .grant       (bus.grant),
        .grant_id    (bus.grant_id),
        .grant_valid (bus.grant_valid)
    );

    always #5 clk = ~clk;

    // Behavioural model: holder index (-1 when idle), consecutive-grant count, last winner.
    int m_holder = -1;
    int m_cnt = 0;
    int m_last = N - 1;

    function automatic int m_pick(input logic [N-1:0] req, input int st, input int excl);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (st + k) % N;
            if (req[j] && j != excl) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        int st;
        int w;
        if (reset) begin
            m_holder = -1;
            m_cnt    = 0;
            m_last   = N - 1;
        end else begin
            st = bus.mode ? (m_last + 1) % N : 0;
            if (m_holder < 0 || !bus.request[m_holder]) begin
                w = m_pick(bus.request, st, -1);
                if (w >= 0) begin
                    m_holder = w; m_cnt = 1; m_last = w;
                end else begin
                    m_holder = -1; m_cnt = 0;
                end
            end else if (m_cnt < MH) begin
                m_cnt = m_cnt + 1;
            end else begin
                w = m_pick(bus.request, st, m_holder);
                if (w >= 0) begin
                    m_holder = w; m_cnt = 1; m_last = w;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] eg;
        if (run_cmp && !reset) begin
            eg = (m_holder < 0) ? '0 : N'(1 << m_holder);
            check("model_grant", 32'(bus.grant), 32'(eg));
            check("model_grant_id", 32'(bus.grant_id), (m_holder < 0) ? 32'd0 : 32'(m_holder));
            check("model_grant_valid", 32'(bus.grant_valid), 32'(m_holder >= 0));
            check("model_hold_cnt", 32'(dut.hold_cnt), 32'(m_cnt));
            check("onehot", 32'($countones(bus.grant) <= 1), 32'd1);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.request = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input string name, input logic [N-1:0] req, input logic [N-1:0] exp);
        @(negedge clk);
        bus.request = req;
        @(posedge clk);
        #1;
        check(name, 32'(bus.grant), 32'(exp));
    endtask

    initial begin
        logic [N-1:0] seq030_req [5] = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [N-1:0] seq030_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [N-1:0] seq031_exp [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                         4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
        int           hold032 [10] = '{1, 2, 3, 4, 4, 4, 4, 4, 4, 4};
        logic [N-1:0] req;

        bus.request = '0;
        bus.mode    = 1'b1;
        repeat (2) @(negedge clk);
        run_cmp = 1'b1;

        do_reset();
        for (int i = 0; i < 3; i++) begin
            step("idle_grant", 4'b0000, 4'b0000);
            check("idle_valid", 32'(bus.grant_valid), 32'd0);
        end

        do_reset();
        bus.mode = 1'b1;
        for (int i = 0; i < 5; i++) step("rr_drop", seq030_req[i], seq030_exp[i]);

        do_reset();
        bus.mode = 1'b1;
        for (int i = 0; i < 9; i++) step("rr_forced", 4'b0011, seq031_exp[i]);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            step("single_hold", 4'b0001, 4'b0001);
            check("single_hold_cnt", 32'(dut.hold_cnt), 32'(hold032[i]));
        end

        do_reset();
        bus.mode = 1'b0;
        step("fixed_first", 4'b1100, 4'b0100);
        step("fixed_keep", 4'b1100, 4'b0100);
        step("fixed_keep3", 4'b1101, 4'b0100);
        step("fixed_keep4", 4'b1101, 4'b0100);
        step("fixed_rotate", 4'b1101, 4'b0001);
        check("fixed_rotate_id", 32'(bus.grant_id), 32'd0);

        do_reset();
        step("pre_reset", 4'b0010, 4'b0010);
        #2;
        reset = 1'b1;
        #1;
        check("async_grant", 32'(bus.grant), 32'd0);
        check("async_valid", 32'(bus.grant_valid), 32'd0);
        check("async_id", 32'(bus.grant_id), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step("post_reset", 4'b1000, 4'b1000);
        check("post_reset_id", 32'(bus.grant_id), 32'd3);

        do_reset();
        req = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) req[b] = ~req[b];
            if ($urandom_range(40) == 0) req = '0;
            if ($urandom_range(40) == 0) req = '1;
            if ($urandom_range(30) == 0) bus.mode = ~bus.mode;
            bus.request = req;
        end

        @(negedge clk);
        run_cmp = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
